// File: rtl/asteroid_pkg.sv
// Shared opcode, mux-select and state definitions for the asteroid update sequencer.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package asteroid_pkg;

   // Entry opcodes stored in the asteroid table
   localparam logic [1:0] OP_EMPTY = 2'b00;
   localparam logic [1:0] OP_RIGHT = 2'b01;
   localparam logic [1:0] OP_DOWN  = 2'b10;
   localparam logic [1:0] OP_DIAG  = 2'b11;

   // Coordinate mux selects
   localparam logic [1:0] SEL_RANDOM = 2'b00;
   localparam logic [1:0] SEL_SOMA_X = 2'b01;
   localparam logic [1:0] SEL_SOMA_Y = 2'b10;
   localparam logic [1:0] SEL_HOLD   = 2'b11;

   typedef enum logic [3:0] {
      IDLE,
      RD_X,
      WT_X,
      WR_X,
      RD_Y,
      WT_Y,
      WR_Y,
      NEXT,
      FIN
   } state_t;

endpackage

// File: rtl/asteroid_update_ctrl_if.sv
// Bundle between the update sequencer and the frame timer / memory / adder / mux datapath.
// Latency: wiring only.
// Backpressure: none; the datapath is assumed to accept a strobe every cycle.
interface asteroid_update_ctrl_if #(
   parameter int N      = 4,
   parameter int ADDR_W = 4
);
   logic              start;
   logic              spawn_req;
   logic [1:0]        mem_opcode;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_re;
   logic              mem_we;
   logic [1:0]        select_mux_coor;
   logic              sel_soma_y;
   logic [N-1:0]      delta;
   logic              spawn_ack;
   logic              busy;
   logic              done;

   // Sequencer side
   modport master (
      input  start, spawn_req, mem_opcode,
      output mem_addr, mem_re, mem_we, select_mux_coor, sel_soma_y, delta,
             spawn_ack, busy, done
   );

   // Timer / datapath side
   modport slave (
      output start, spawn_req, mem_opcode,
      input  mem_addr, mem_re, mem_we, select_mux_coor, sel_soma_y, delta,
             spawn_ack, busy, done
   );
endinterface

// File: rtl/asteroid_update_ctrl_opcode_delta.sv
// Decodes an entry opcode into signed per-axis increments (all ones = -1).
// Latency: combinational.
// Backpressure: not applicable.
module opcode_delta
   import asteroid_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [1:0]   opcode,
   output logic [N-1:0] dx,
   output logic [N-1:0] dy
);

   // Map each movement opcode to its two's-complement step pair
   always_comb begin
      dx = '0;
      dy = '0;
      case (opcode)
         OP_RIGHT: dx = N'(1);
         OP_DOWN:  dy = N'(1);
         OP_DIAG: begin
            dx = '1;
            dy = '1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/asteroid_update_ctrl.sv
// Walks the asteroid table once per start, writing X then Y deltas and at most one spawn.
// Latency: 7/4/3 cycles per active/spawn/empty entry plus 1 FIN cycle; busy the cycle after start.
// Backpressure: none; start while busy is dropped, spawn_req held by requester until spawn_ack.
module asteroid_update_ctrl
   import asteroid_pkg::*;
#(
   parameter int N      = 4,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   asteroid_update_ctrl_if.master bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state_q, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        op_q;
   logic              spawn_mode_q;   // current WR_X writes a spawn rather than a move
   logic              spawn_done_q;   // a spawn already happened this pass
   logic [N-1:0]      dx, dy;

   opcode_delta #(.N(N)) u_opcode_delta (
      .opcode (op_q),
      .dx     (dx),
      .dy     (dy)
   );

   // State, address walk, opcode latch and spawn bookkeeping
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         op_q         <= OP_EMPTY;
         spawn_mode_q <= 1'b0;
         spawn_done_q <= 1'b0;
      end else begin
         state_q <= state_nxt;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  addr_q       <= '0;
                  spawn_done_q <= 1'b0;
               end
            end
            WT_X: begin
               op_q         <= bus.mem_opcode;
               spawn_mode_q <= (bus.mem_opcode == OP_EMPTY);
            end
            WR_X: begin
               if (spawn_mode_q) spawn_done_q <= 1'b1;
            end
            NEXT: begin
               if (addr_q != LAST_ADDR) addr_q <= addr_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Next-state sequencing through one table pass
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE: if (bus.start) state_nxt = RD_X;
         RD_X: state_nxt = WT_X;
         WT_X: begin
            if (bus.mem_opcode != OP_EMPTY)              state_nxt = WR_X;
            else if (bus.spawn_req && !spawn_done_q)     state_nxt = WR_X;
            else                                         state_nxt = NEXT;
         end
         WR_X: state_nxt = spawn_mode_q ? NEXT : RD_Y;
         RD_Y: state_nxt = WT_Y;
         WT_Y: state_nxt = WR_Y;
         WR_Y: state_nxt = NEXT;
         NEXT: state_nxt = (addr_q == LAST_ADDR) ? FIN : RD_X;
         FIN:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Moore output decode from the registered state
   always_comb begin
      bus.mem_re          = 1'b0;
      bus.mem_we          = 1'b0;
      bus.select_mux_coor = SEL_HOLD;
      bus.sel_soma_y      = 1'b0;
      bus.delta           = '0;
      bus.spawn_ack       = 1'b0;
      bus.done            = 1'b0;
      bus.busy            = (state_q != IDLE);
      bus.mem_addr        = addr_q;
      case (state_q)
         RD_X, RD_Y: bus.mem_re = 1'b1;
         WR_X: begin
            bus.mem_we = 1'b1;
            if (spawn_mode_q) begin
               bus.select_mux_coor = SEL_RANDOM;
               bus.spawn_ack       = 1'b1;
            end else begin
               bus.select_mux_coor = SEL_SOMA_X;
               bus.delta           = dx;
            end
         end
         WR_Y: begin
            bus.mem_we          = 1'b1;
            bus.select_mux_coor = SEL_SOMA_Y;
            bus.sel_soma_y      = 1'b1;
            bus.delta           = dy;
         end
         FIN: bus.done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_asteroid_update_ctrl.sv
// Bench for asteroid_update_ctrl with a small table/adder/mux datapath and a per-pass reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_asteroid_update_ctrl;
   import asteroid_pkg::*;

   localparam int N      = 4;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 2;
   localparam logic [13:0] RESET_VEC = {1'b0, 1'b0, 2'b11, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'b00};

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   asteroid_update_ctrl_if #(.N(N), .ADDR_W(ADDR_W)) bus ();

   asteroid_update_ctrl #(.N(N), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Table contents and the synchronous read register of the datapath
   logic [1:0]   t_op [DEPTH];
   logic [N-1:0] t_x  [DEPTH];
   logic [N-1:0] t_y  [DEPTH];
   logic [1:0]   rd_op;
   logic [N-1:0] rd_x, rd_y;
   logic [1:0]   sp_op;
   logic [N-1:0] sp_x, sp_y;

   assign bus.mem_opcode = rd_op;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [13:0] outvec();
      return {bus.mem_re, bus.mem_we, bus.select_mux_coor, bus.sel_soma_y, bus.delta,
              bus.spawn_ack, bus.busy, bus.done, bus.mem_addr};
   endfunction

   function automatic logic [15:0] wkey(int a, int s, int so, int d);
      return 16'((a << 8) | (s << 6) | (so << 4) | d);
   endfunction

   // One clock of the datapath: strobes seen just before the edge take effect after it
   task automatic tick();
      logic         p_re, p_we, p_soma;
      logic [1:0]   p_sel;
      logic [ADDR_W-1:0] p_addr;
      logic [N-1:0] p_delta, sum;
      p_re = bus.mem_re; p_we = bus.mem_we; p_sel = bus.select_mux_coor;
      p_soma = bus.sel_soma_y; p_addr = bus.mem_addr; p_delta = bus.delta;
      @(posedge clock);
      #1;
      sum = (p_soma ? rd_y : rd_x) + p_delta;
      if (p_re === 1'b1) begin
         rd_op = t_op[p_addr]; rd_x = t_x[p_addr]; rd_y = t_y[p_addr];
      end
      if (p_we === 1'b1) begin
         case (p_sel)
            2'b00: begin t_op[p_addr] = sp_op; t_x[p_addr] = sp_x; t_y[p_addr] = sp_y; end
            2'b01: t_x[p_addr] = sum;
            2'b10: t_y[p_addr] = sum;
            default: ;
         endcase
      end
   endtask

   // Runs one pass and compares it with what the movement rules predict
   task automatic run_pass(input bit req, input bit extra_start);
      logic [1:0]   m_op [DEPTH];
      logic [N-1:0] m_x  [DEPTH];
      logic [N-1:0] m_y  [DEPTH];
      logic [15:0]  ewr[$], gwr[$];
      int ecycles = 1, eacks = 0, eack_addr = -1;
      int cyc = 0, done_n = 0, done_at = -1, acks = 0, ack_addr = -1, ack_sel = -1;
      int idle_bad = 0, late = 0;
      bit spawned = 0;
      for (int i = 0; i < DEPTH; i++) begin
         int dx, dy;
         m_op[i] = t_op[i]; m_x[i] = t_x[i]; m_y[i] = t_y[i];
         dx = (m_op[i] == 2'd1) ? 1 : (m_op[i] == 2'd3) ? 15 : 0;
         dy = (m_op[i] == 2'd2) ? 1 : (m_op[i] == 2'd3) ? 15 : 0;
         if (m_op[i] != 2'd0) begin
            ewr.push_back(wkey(i, 1, 0, dx));
            ewr.push_back(wkey(i, 2, 1, dy));
            m_x[i] = N'(m_x[i] + dx);
            m_y[i] = N'(m_y[i] + dy);
            ecycles += 7;
         end else if (req && !spawned) begin
            ewr.push_back(wkey(i, 0, 0, 0));
            m_op[i] = sp_op; m_x[i] = sp_x; m_y[i] = sp_y;
            spawned = 1; eacks = 1; eack_addr = i;
            ecycles += 4;
         end else begin
            ecycles += 3;
         end
      end

      bus.start = 1'b1;
      bus.spawn_req = req;
      tick();
      bus.start = 1'b0;
      check("busy_rise", 32'(bus.busy), 32'd1);
      check("start_addr", 32'(bus.mem_addr), 32'd0);

      while (bus.busy === 1'b1 && cyc < 300) begin
         cyc++;
         if (bus.mem_we === 1'b1) begin
            if (bus.select_mux_coor == 2'b00) gwr.push_back(wkey(int'(bus.mem_addr), 0, 0, 0));
            else gwr.push_back(wkey(int'(bus.mem_addr), int'(bus.select_mux_coor),
                                    int'(bus.sel_soma_y), int'(bus.delta)));
         end else if (bus.select_mux_coor !== 2'b11 || bus.delta !== '0) begin
            idle_bad++;
         end
         if (bus.spawn_ack === 1'b1) begin
            acks++; ack_addr = int'(bus.mem_addr); ack_sel = int'(bus.select_mux_coor);
            bus.spawn_req = 1'b0;
         end
         if (bus.done === 1'b1) begin done_n++; done_at = cyc; end
         if (extra_start) bus.start = (cyc == 6);
         tick();
      end
      bus.start = 1'b0;
      bus.spawn_req = 1'b0;

      check("pass_cycles", 32'(cyc), 32'(ecycles));
      check("busy_fall", 32'(bus.busy), 32'd0);
      check("done_count", 32'(done_n), 32'd1);
      check("done_last", 32'(done_at), 32'(cyc));
      check("write_count", 32'(gwr.size()), 32'(ewr.size()));
      for (int k = 0; k < ewr.size() && k < gwr.size(); k++)
         check("write_fields", 32'(gwr[k]), 32'(ewr[k]));
      check("hold_outside_wr", 32'(idle_bad), 32'd0);
      check("ack_count", 32'(acks), 32'(eacks));
      if (eacks == 1) begin
         check("ack_addr", 32'(ack_addr), 32'(eack_addr));
         check("ack_sel", 32'(ack_sel), 32'd0);
      end
      for (int i = 0; i < DEPTH; i++)
         check("table_entry", {22'd0, t_op[i], t_x[i], t_y[i]}, {22'd0, m_op[i], m_x[i], m_y[i]});
      repeat (5) begin
         tick();
         if (bus.busy !== 1'b0 || bus.done !== 1'b0) late++;
      end
      check("no_requeue", 32'(late), 32'd0);
   endtask

   initial begin
      logic [N-1:0] x1, y1;
      int w;
      bit found;
      reset_n = 1'b0;
      bus.start = 1'b0;
      bus.spawn_req = 1'b0;
      rd_op = '0; rd_x = '0; rd_y = '0;
      sp_op = 2'd1; sp_x = '0; sp_y = '0;
      for (int i = 0; i < DEPTH; i++) begin t_op[i] = '0; t_x[i] = '0; t_y[i] = '0; end
      #1;
      check("reset_vals", 32'(outvec()), 32'(RESET_VEC));
      tick(); tick();
      reset_n = 1'b1;
      tick();
      check("idle_vals", 32'(outvec()), 32'(RESET_VEC));

      // All empty, no spawn: 13 busy cycles, no writes
      for (int i = 0; i < DEPTH; i++) begin
         t_op[i] = 2'd0; t_x[i] = N'($urandom); t_y[i] = N'($urandom);
      end
      run_pass(0, 0);

      // X wraps on +1 at 15; diagonal step from origin wraps to 15,15
      t_op[0] = 2'd1; t_x[0] = 4'd15; t_y[0] = 4'd3;
      t_op[1] = 2'd0;
      t_op[2] = 2'd3; t_x[2] = 4'd0;  t_y[2] = 4'd0;
      t_op[3] = 2'd0;
      run_pass(0, 0);
      check("wrap_x0", 32'(t_x[0]), 32'd0);
      check("keep_y0", 32'(t_y[0]), 32'd3);
      check("diag_x2", 32'(t_x[2]), 32'd15);
      check("diag_y2", 32'(t_y[2]), 32'd15);

      // Single spawn at the first empty slot, plus a start pulse mid-pass
      t_op[0] = 2'd0; t_op[1] = 2'd0; t_op[2] = 2'd1; t_op[3] = 2'd0;
      x1 = t_x[1];
      sp_op = 2'd2; sp_x = 4'd9; sp_y = 4'd6;
      run_pass(1, 1);
      check("slot1_untouched", {26'd0, t_op[1], x1}, {26'd0, 2'd0, t_x[1]});

      // Randomised passes
      for (int p = 0; p < 8; p++) begin
         for (int i = 0; i < DEPTH; i++) begin
            t_op[i] = 2'($urandom_range(0, 3));
            t_x[i] = N'($urandom); t_y[i] = N'($urandom);
         end
         sp_op = 2'($urandom_range(1, 3)); sp_x = N'($urandom); sp_y = N'($urandom);
         run_pass(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // Reset during WR_Y of entry 1 aborts the write and returns to IDLE
      t_op[0] = 2'd1; t_op[1] = 2'd2; t_op[2] = 2'd3; t_op[3] = 2'd0;
      t_y[1] = 4'd7;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      w = 0; found = 0;
      while (!found && w < 100) begin
         if (bus.mem_we === 1'b1 && bus.select_mux_coor === 2'b10 && bus.mem_addr === 2'd1)
            found = 1;
         else begin
            tick(); w++;
         end
      end
      check("reach_wr_y1", 32'(found), 32'd1);
      y1 = t_y[1];
      reset_n = 1'b0;
      #1;
      check("midpass_reset_vals", 32'(outvec()), 32'(RESET_VEC));
      tick(); tick();
      check("aborted_write", 32'(t_y[1]), 32'(y1));
      reset_n = 1'b1;
      tick();
      run_pass(0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/asteroid_update_ctrl.md
# asteroid_update_ctrl

Frame-tick sequencer for the asteroid coordinate datapath: on each `start` it walks the asteroid table once, reading each entry, steering the coordinate mux (`select_mux_coor`), feeding the external adder a signed delta, and writing updated X then Y back to the table. Empty slots may be filled with a random spawn when one is requested. It sits between the frame timer and the asteroid memory + adder + coordinate mux datapath.

## Interface
- `N`, 4, coordinate width in bits
- `DEPTH`, 16, number of table entries
- `ADDR_W`, 4, address width; DEPTH ≤ 2^ADDR_W

- `clock` in 1, single clock, rising edge
- `reset_n` in 1, asynchronous, active-low reset
- `start` in 1, begin one table pass; ignored while `busy`
- `spawn_req` in 1, level request to place one random asteroid
- `mem_opcode` in 2, opcode field of the entry read last cycle
- `mem_addr` out ADDR_W, table address
- `mem_re` out 1, read strobe; synchronous RAM, data valid next cycle
- `mem_we` out 1, write strobe; writes mux output at `mem_addr`
- `select_mux_coor` out 2, 00 random spawn, 01 X sum, 10 Y sum, 11 pass-through
- `sel_soma_y` out 1, adder operand select: 0 = mem X, 1 = mem Y
- `delta` out N, two's-complement increment to adder
- `spawn_ack` out 1, one-cycle pulse when a spawn is written
- `busy` out 1, pass in progress
- `done` out 1, one-cycle pulse at end of pass

## Operation
- Opcodes: 00 empty slot; 01 (dx +1, dy 0); 10 (dx 0, dy +1); 11 (dx −1, dy −1). −1 = all ones in N bits.
- States: IDLE, RD_X, WT_X, WR_X, RD_Y, WT_Y, WR_Y, NEXT, FIN.
- IDLE: `start`=1 → RD_X, addr := 0, `spawn_done` flag := 0.
- RD_X: `mem_re`=1 → WT_X.
- WT_X: opcode valid. Opcode ≠ 00 → WR_X. Opcode 00 with `spawn_req`=1 and `spawn_done`=0 → WR_X (spawn). Otherwise → NEXT.
- WR_X, active: `select_mux_coor`=01, `sel_soma_y`=0, `delta`=dx, `mem_we`=1 → RD_Y.
- WR_X, spawn: `select_mux_coor`=00, `mem_we`=1, `spawn_ack`=1, `spawn_done` := 1 → NEXT. No movement on the spawn pass.
- RD_Y: `mem_re`=1 (re-reads the freshly written X) → WT_Y → WR_Y.
- WR_Y: `select_mux_coor`=10, `sel_soma_y`=1, `delta`=dy, `mem_we`=1 → NEXT. Written even when dy=0.
- Opcode latched in WT_X; the WT_Y value is not re-decoded.
- NEXT: addr = DEPTH−1 → FIN, else addr+1 → RD_X.
- FIN: `done`=1 → IDLE.
- Arithmetic: adder is external and modulo 2^N, so coordinates wrap at screen edge. The block emits only deltas.
- At most one spawn per pass. `spawn_req` is sampled only in WT_X of empty slots. Requester holds it until `spawn_ack`, and drops it on or after the cycle following `spawn_ack`.
- `start` during a pass is dropped, not queued. `start` held high re-triggers on the cycle after FIN.

## Timing
- All outputs registered-state decoded (Moore). `mem_addr` is stable from RD_X through WR_Y of an entry.
- Reset values: state IDLE, `mem_addr`=0, `mem_re`=0, `mem_we`=0, `select_mux_coor`=11, `sel_soma_y`=0, `delta`=0, `spawn_ack`=0, `busy`=0, `done`=0.
- Outside WR_X/WR_Y: `select_mux_coor`=11, `delta`=0.
- `busy`=1 in every state except IDLE, asserted the cycle after `start` is sampled.
- Per entry: active 7 cycles, spawn 4, empty 3 (including NEXT). Plus 1 cycle FIN.
- Reset mid-pass: immediate return to IDLE with reset values. Any in-flight write is aborted because `mem_we` falls asynchronously. No partial-pass resume.

## Structure
- Package `asteroid_pkg`: opcode constants (OP_EMPTY, OP_RIGHT, OP_DOWN, OP_DIAG), mux select constants (SEL_RANDOM, SEL_SOMA_X, SEL_SOMA_Y, SEL_HOLD), state enum.
- One sub-module `opcode_delta`: combinational opcode → {dx, dy}, parameterised by N.

## Test plan
- DEPTH=4, all opcodes 00, `spawn_req`=0, `start` pulse → no `mem_we`, `done` 13 cycles after `busy` rises, `busy` low next cycle.
- Entry 0 opcode 01, X=15, Y=3 → WR_X select 01, delta 1. Adder wraps: X=0. WR_Y select 10, delta 0, Y=3.
- Entry 2 opcode 11, X=0, Y=0 → delta 4'hF on both writes; stored X=15, Y=15.
- Opcodes {00,00,01,00}, `spawn_req` held → exactly one `spawn_ack`, at addr 0 with select 00. Addr 1 not written. `spawn_req` dropped after ack.
- `start` pulsed again mid-pass → ignored; exactly one `done` per original start.
- `reset_n` low during WR_Y of entry 1 → outputs at reset values immediately. Next `start` restarts at addr 0.
